// File: rtl/keyword_scan_arbiter_pkg.sv
// Shared constants and types for the "BOMB" keyword scanner.
// Holds the ASCII keyword letters and the 2-bit match-state encoding.
package keyword_scan_arbiter_pkg;

    localparam logic [7:0] KW_B = 8'h42;
    localparam logic [7:0] KW_O = 8'h4F;
    localparam logic [7:0] KW_M = 8'h4D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        S_B   = 2'd1,
        S_BO  = 2'd2,
        S_BOM = 2'd3
    } matchState_t;

endpackage

// File: rtl/keyword_scan_arbiter_if.sv
// Byte-stream request bundle and alert/counter outputs of the shared keyword scanner.
// The master side is the text sources plus reporting logic; the slave side is the scanner.
interface keyword_scan_arbiter_if
    import keyword_scan_arbiter_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    localparam int CW = $clog2(NCH);

    logic                   en;
    logic [NCH-1:0]         reqValid;
    logic [8*NCH-1:0]       reqData;
    logic [NCH-1:0]         reqReady;
    logic [NCH-1:0]         chanClr;
    logic                   alertValid;
    logic [CW-1:0]          alertChan;
    logic [NCH*CNT_W-1:0]   hitCnt;

    modport master (
        output en, reqValid, reqData, chanClr,
        input  reqReady, alertValid, alertChan, hitCnt
    );

    modport slave (
        input  en, reqValid, reqData, chanClr,
        output reqReady, alertValid, alertChan, hitCnt
    );

endinterface

// File: rtl/keyword_scan_arbiter_kw_step.sv
// One step of the "BOMB" matcher: (state, byte) -> (next state, hit).
// Purely combinational so it can be shared by whichever channel is granted.
module kw_step
    import keyword_scan_arbiter_pkg::*;
(
    input  matchState_t state_i,
    input  logic [7:0]  byte_i,
    output matchState_t nextState_o,
    output logic        hit_o
);

    // A 'B' always restarts the keyword, so overlapping matches like "BOMBOMB" hit twice
    always_comb begin
        nextState_o = IDLE;
        hit_o       = 1'b0;
        if (byte_i == KW_B) begin
            nextState_o = S_B;
            hit_o       = (state_i == S_BOM);
        end else if (state_i == S_B && byte_i == KW_O) begin
            nextState_o = S_BO;
        end else if (state_i == S_BO && byte_i == KW_M) begin
            nextState_o = S_BOM;
        end
    end

endmodule

// File: rtl/keyword_scan_arbiter.sv
// Round-robin arbiter sharing one "BOMB" matcher across NCH byte streams,
// with per-channel saved match context, tagged alerts and saturating hit counters.
module keyword_scan_arbiter
    import keyword_scan_arbiter_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    keyword_scan_arbiter_if.slave bus
);

    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]   eligible;
    logic [NCH-1:0]   grant;
    logic             grantAny;
    logic [CW-1:0]    grantIdx;
    logic [CW-1:0]    cand;
    logic [CW-1:0]    ptr_q, ptr_d;

    matchState_t      matchState_q [NCH];
    logic [CNT_W-1:0] hitCnt_q [NCH];

    matchState_t      selState;
    matchState_t      stepNext;
    logic [7:0]       selByte;
    logic             stepHit;

    logic             alertValid_q, alertValid_d;
    logic [CW-1:0]    alertChan_q, alertChan_d;

    // Search starts just after the last granted channel; a channel being cleared is skipped
    always_comb begin
        eligible = bus.reqValid & ~bus.chanClr & {NCH{bus.en}};
        grantAny = 1'b0;
        grantIdx = '0;
        cand     = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CW'((int'(ptr_q) + k) % NCH);
            if (!grantAny && eligible[cand]) begin
                grantAny = 1'b1;
                grantIdx = cand;
            end
        end
        grant = grantAny ? (NCH'(1) << grantIdx) : '0;
        ptr_d = grantAny ? grantIdx : ptr_q;
    end

    always_comb begin
        selState = IDLE;
        selByte  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grantIdx == CW'(i)) begin
                selState = matchState_q[i];
                selByte  = bus.reqData[8*i +: 8];
            end
        end
    end

    kw_step uStep (
        .state_i     (selState),
        .byte_i      (selByte),
        .nextState_o (stepNext),
        .hit_o       (stepHit)
    );

    always_comb begin
        alertValid_d = grantAny & stepHit;
        alertChan_d  = (grantAny && stepHit) ? grantIdx : alertChan_q;
    end

    // Pointer resets to the last channel so channel 0 wins the first arbitration
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q        <= CW'(NCH - 1);
            alertValid_q <= 1'b0;
            alertChan_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                matchState_q[i] <= IDLE;
                hitCnt_q[i]     <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            alertValid_q <= alertValid_d;
            alertChan_q  <= alertChan_d;
            for (int i = 0; i < NCH; i++) begin
                if (bus.chanClr[i]) begin
                    matchState_q[i] <= IDLE;
                    hitCnt_q[i]     <= '0;
                end else if (grantAny && grantIdx == CW'(i)) begin
                    matchState_q[i] <= stepNext;
                    if (stepHit && hitCnt_q[i] != {CNT_W{1'b1}}) begin
                        hitCnt_q[i] <= hitCnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.hitCnt = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.hitCnt[i*CNT_W +: CNT_W] = hitCnt_q[i];
        end
    end

    assign bus.reqReady   = grant;
    assign bus.alertValid = alertValid_q;
    assign bus.alertChan  = alertChan_q;

endmodule
